// File: rtl/apb_fabric.sv
// APB decoder/multiplexer: one-hot slave select, response mux, unmapped-address
// error, per-transfer timeout watchdog and an internal IRQ/status register slot.
module apb_fabric #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_SLAVES = 4,
  parameter int unsigned           SLOT_BITS  = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000,
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             s_psel,
  input  logic                             s_penable,
  input  logic                             s_pwrite,
  input  logic [ADDR_WIDTH-1:0]            s_paddr,
  input  logic [DATA_WIDTH-1:0]            s_pwdata,
  output logic [DATA_WIDTH-1:0]            s_prdata,
  output logic                             s_pready,
  output logic                             s_pslverr,
  output logic [NUM_SLAVES-1:0]            m_psel,
  output logic                             m_penable,
  output logic                             m_pwrite,
  output logic [ADDR_WIDTH-1:0]            m_paddr,
  output logic [DATA_WIDTH-1:0]            m_pwdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_prdata,
  input  logic [NUM_SLAVES-1:0]            m_pready,
  input  logic [NUM_SLAVES-1:0]            m_pslverr,
  input  logic [NUM_SLAVES-1:0]            irq_i,
  output logic                             irq_o
);

  localparam int unsigned RB     = SLOT_BITS + 4;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ABORT} state_t;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] pending_q, pending_d;
  logic [NUM_SLAVES-1:0] enable_q, enable_d;
  logic                  to_flag_q, to_flag_d;
  logic [3:0]            to_idx_q, to_idx_d;
  logic                  irq_q, irq_d;

  logic [3:0]            idx;
  logic [3:0]            off;
  logic                  in_region, mapped, internal;
  logic                  psel_ok, access, complete, to_hit, reg_wr;
  logic                  sel_pready, sel_pslverr;
  logic [DATA_WIDTH-1:0] sel_prdata, reg_rdata;
  logic [15:0]           cnt_inc;
  logic [NUM_SLAVES-1:0] clr;

  assign m_penable = s_penable;
  assign m_pwrite  = s_pwrite;
  assign m_paddr   = s_paddr;
  assign m_pwdata  = s_pwdata;
  assign irq_o     = irq_q;

  // Address decode, slave select and per-slave response selection
  always_comb begin
    idx         = s_paddr[SLOT_BITS +: 4];
    off         = s_paddr[3:0];
    in_region   = (s_paddr[ADDR_WIDTH-1:RB] == BASE_ADDR[ADDR_WIDTH-1:RB]);
    mapped      = in_region && (32'(idx) < NUM_SLAVES);
    internal    = in_region && (idx == 4'hF);
    psel_ok     = (state_q != ST_ABORT);
    access      = s_psel && s_penable && psel_ok;
    m_psel      = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx == 4'(i)) begin
        m_psel[i]   = psel_ok && mapped && s_psel;
        sel_pready  = m_pready[i];
        sel_pslverr = m_pslverr[i];
        sel_prdata  = m_prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    complete = mapped ? sel_pready : 1'b1;
    to_hit   = access && (state_q == ST_ACCESS) && mapped && !sel_pready &&
               (TIMEOUT != 0) && (cnt_q == TO_LIM);
    reg_wr   = access && internal && s_pwrite;
  end

  // Internal register slot read mux
  always_comb begin
    reg_rdata = '0;
    case (off)
      4'h0: reg_rdata[NUM_SLAVES-1:0] = pending_q;
      4'h4: reg_rdata[NUM_SLAVES-1:0] = enable_q;
      4'hC: begin
        reg_rdata[0]   = to_flag_q;
        reg_rdata[7:4] = to_idx_q;
      end
      default: reg_rdata = '0;
    endcase
  end

  // Upstream response: timeout error, slave mux, internal slot or unmapped error
  always_comb begin
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    s_prdata  = '0;
    if (access) begin
      if (to_hit) begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
      end else if (mapped) begin
        s_pready  = sel_pready;
        s_pslverr = sel_pslverr;
        s_prdata  = sel_prdata;
      end else if (internal) begin
        s_pready  = 1'b1;
        s_prdata  = reg_rdata;
      end else begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
      end
    end
  end

  // Transfer FSM and saturating wait counter; the first access cycle is seen in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == TO_LIM) ? cnt_q : cnt_q + 16'd1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (access && !complete) begin
          state_d = ST_ACCESS;
          cnt_d   = cnt_inc;
        end
      end
      ST_ACCESS: begin
        // A dropped access phase also returns to IDLE so the FSM cannot stick.
        if (!access || complete) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (to_hit) begin
          state_d = ST_ABORT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_ABORT: begin
        if (!s_psel || !s_penable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register slot updates, interrupt pending/enable and aggregated irq
  always_comb begin
    enable_d  = enable_q;
    clr       = '0;
    to_flag_d = to_flag_q;
    to_idx_d  = to_idx_q;
    if (reg_wr && (off == 4'h4)) enable_d = s_pwdata[NUM_SLAVES-1:0];
    if (reg_wr && (off == 4'h8)) clr = s_pwdata[NUM_SLAVES-1:0];
    if (reg_wr && (off == 4'hC) && s_pwdata[0]) to_flag_d = 1'b0;
    if (to_hit) begin
      to_flag_d = 1'b1;
      to_idx_d  = idx;
    end
    pending_d = (pending_q & ~clr) | irq_i;
    irq_d     = |(pending_q & enable_q);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      to_flag_q <= 1'b0;
      to_idx_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      to_flag_q <= to_flag_d;
      to_idx_q  <= to_idx_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_apb_fabric.sv
// Self-checking bench for apb_fabric: vector table plus timeout, interrupt and
// reset sequences; expected responses travel through a scoreboard queue.
module tb_apb_fabric;

  logic         clk = 1'b0;
  logic         resetn;
  logic         s_psel, s_penable, s_pwrite;
  logic [31:0]  s_paddr, s_pwdata, s_prdata;
  logic         s_pready, s_pslverr;
  logic [3:0]   m_psel;
  logic         m_penable, m_pwrite;
  logic [31:0]  m_paddr, m_pwdata;
  logic [127:0] m_prdata;
  logic [3:0]   m_pready, m_pslverr, irq_i;
  logic         irq_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          sl;
    int          wait_n;
    logic        serr;
    logic [3:0]  psel;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[21];

  apb_fabric #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .SLOT_BITS(12),
    .BASE_ADDR(32'h4000_0000), .TIMEOUT(8)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .irq_i(irq_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int sl, input int wait_n, input logic serr,
                              input logic [3:0] psel, input logic [31:0] rdata,
                              input logic err, input int cycles);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.sl = sl; v.wait_n = wait_n;
    v.serr = serr; v.psel = psel; v.rdata = rdata; v.err = err; v.cycles = cycles;
    return v;
  endfunction

  task automatic drive_ready(input vec_t v, input int cyc);
    m_pready  = '0;
    m_pslverr = '0;
    if (v.sl >= 0 && v.wait_n >= 0 && cyc > v.wait_n) begin
      m_pready[v.sl[1:0]]  = 1'b1;
      m_pslverr[v.sl[1:0]] = v.serr;
    end
  endtask

  // One APB transfer; leaves psel/penable asserted so the next call is back-to-back.
  task automatic run(input vec_t v);
    vec_t e;
    int   cyc;
    bit   done;
    exp_q.push_back(v);
    @(posedge clk); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = v.addr; s_pwrite = v.wr; s_pwdata = v.wdata;
    m_pready = '0; m_pslverr = '0;
    @(negedge clk);
    chk("setup_pready", 32'(s_pready), 32'd0);
    chk("setup_psel", 32'(m_psel), 32'(v.psel));
    @(posedge clk); #1;
    s_penable = 1'b1;
    cyc = 1;
    drive_ready(v, cyc);
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (cyc == 1) chk("access_psel", 32'(m_psel), 32'(v.psel));
      if (s_pready) begin
        e = exp_q.pop_front();
        chk("rdata", s_prdata, e.rdata);
        chk("pslverr", 32'(s_pslverr), 32'(e.err));
        chk("cycles", 32'(cyc), 32'(e.cycles));
        done = 1;
      end else if (cyc >= 40) begin
        e = exp_q.pop_front();
        n_checks++; n_errors++;
        $display("FAIL response_wait: no pready after %0d cycles, required at cycle %0d", cyc, e.cycles);
        done = 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        drive_ready(v, cyc);
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    s_psel = 1'b0; s_penable = 1'b0; m_pready = '0; m_pslverr = '0;
  endtask

  initial begin
    vecs[0]  = mk(0, 32'h4000_2010, 0, 2, 3, 0, 4'b0100, 32'hA5A5_0002, 0, 4);
    vecs[1]  = mk(0, 32'h4000_5000, 0, -1, 0, 0, 4'b0000, 32'h0, 1, 1);
    vecs[2]  = mk(0, 32'h5000_0000, 0, -1, 0, 0, 4'b0000, 32'h0, 1, 1);
    vecs[3]  = mk(0, 32'h4000_4000, 0, -1, 0, 0, 4'b0000, 32'h0, 1, 1);
    vecs[4]  = mk(0, 32'h4000_E000, 0, -1, 0, 0, 4'b0000, 32'h0, 1, 1);
    vecs[5]  = mk(0, 32'h4001_F000, 0, -1, 0, 0, 4'b0000, 32'h0, 1, 1);
    vecs[6]  = mk(1, 32'h4000_0008, 32'h1234, 0, 0, 0, 4'b0001, 32'hA5A5_0000, 0, 1);
    vecs[7]  = mk(0, 32'h4000_3004, 0, 3, 0, 0, 4'b1000, 32'hA5A5_0003, 0, 1);
    vecs[8]  = mk(1, 32'h4000_0010, 32'h5678, 0, 0, 0, 4'b0001, 32'hA5A5_0000, 0, 1);
    vecs[9]  = mk(0, 32'h4000_3FFC, 0, 3, 0, 0, 4'b1000, 32'hA5A5_0003, 0, 1);
    vecs[10] = mk(0, 32'h4000_1000, 0, 1, 1, 1, 4'b0010, 32'hA5A5_0001, 1, 2);
    vecs[11] = mk(1, 32'h4000_F004, 32'hFFFF_FFFF, -1, 0, 0, 4'b0000, 32'h0, 0, 1);
    vecs[12] = mk(0, 32'h4000_F004, 0, -1, 0, 0, 4'b0000, 32'hF, 0, 1);
    vecs[13] = mk(1, 32'h4000_F004, 32'h5, -1, 0, 0, 4'b0000, 32'hF, 0, 1);
    vecs[14] = mk(0, 32'h4000_F004, 0, -1, 0, 0, 4'b0000, 32'h5, 0, 1);
    vecs[15] = mk(1, 32'h4000_F002, 32'hFFFF_FFFF, -1, 0, 0, 4'b0000, 32'h0, 0, 1);
    vecs[16] = mk(0, 32'h4000_F004, 0, -1, 0, 0, 4'b0000, 32'h5, 0, 1);
    vecs[17] = mk(1, 32'h4000_F004, 32'h0, -1, 0, 0, 4'b0000, 32'h5, 0, 1);
    vecs[18] = mk(0, 32'h4000_F000, 0, -1, 0, 0, 4'b0000, 32'h0, 0, 1);
    vecs[19] = mk(0, 32'h4000_F008, 0, -1, 0, 0, 4'b0000, 32'h0, 0, 1);
    vecs[20] = mk(0, 32'h4000_F00C, 0, -1, 0, 0, 4'b0000, 32'h0, 0, 1);

    resetn = 1'b0; s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
    s_paddr = '0; s_pwdata = '0; m_pready = '0; m_pslverr = '0; irq_i = '0;
    m_prdata = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_psel", 32'(m_psel), 32'd0);
    chk("rst_pready", 32'(s_pready), 32'd0);
    chk("rst_pslverr", 32'(s_pslverr), 32'd0);
    chk("rst_prdata", s_prdata, 32'd0);
    chk("rst_irq_o", 32'(irq_o), 32'd0);

    // Vector table, applied back-to-back
    for (int i = 0; i < 21; i++) run(vecs[i]);
    idle();

    // Timeout on slave 1, late ready ignored, TO_STATUS set and W1C
    run(mk(0, 32'h4000_1000, 0, 1, -1, 0, 4'b0010, 32'h0, 1, 9));
    @(posedge clk); #1;
    m_pready[1] = 1'b1;
    @(negedge clk);
    chk("psel_after_timeout", 32'(m_psel), 32'd0);
    chk("late_ready_ignored", 32'(s_pready), 32'd0);
    idle();
    run(mk(0, 32'h4000_F00C, 0, -1, 0, 0, 4'b0000, 32'h11, 0, 1));
    run(mk(1, 32'h4000_F00C, 32'h1, -1, 0, 0, 4'b0000, 32'h11, 0, 1));
    run(mk(0, 32'h4000_F00C, 0, -1, 0, 0, 4'b0000, 32'h10, 0, 1));
    idle();

    // Interrupt pulse latency, clear blocked by active irq, then effective clear
    run(mk(1, 32'h4000_F004, 32'h8, -1, 0, 0, 4'b0000, 32'h0, 0, 1));
    idle();
    @(posedge clk); #1 irq_i[3] = 1'b1;
    @(negedge clk); chk("irq_o_t0", 32'(irq_o), 32'd0);
    @(posedge clk); #1 irq_i[3] = 1'b0;
    @(negedge clk); chk("irq_o_t1", 32'(irq_o), 32'd0);
    @(negedge clk); chk("irq_o_t2", 32'(irq_o), 32'd1);
    run(mk(0, 32'h4000_F000, 0, -1, 0, 0, 4'b0000, 32'h8, 0, 1));
    irq_i[3] = 1'b1;
    run(mk(1, 32'h4000_F008, 32'h8, -1, 0, 0, 4'b0000, 32'h0, 0, 1));
    run(mk(0, 32'h4000_F000, 0, -1, 0, 0, 4'b0000, 32'h8, 0, 1));
    idle();
    irq_i[3] = 1'b0;
    run(mk(1, 32'h4000_F008, 32'h8, -1, 0, 0, 4'b0000, 32'h0, 0, 1));
    idle();
    @(negedge clk); chk("irq_o_hold", 32'(irq_o), 32'd1);
    @(negedge clk); chk("irq_o_cleared", 32'(irq_o), 32'd0);
    run(mk(0, 32'h4000_F000, 0, -1, 0, 0, 4'b0000, 32'h0, 0, 1));
    idle();

    // Reset during a slave-1 wait state
    @(posedge clk); #1 irq_i[3] = 1'b1;
    @(posedge clk); #1 irq_i[3] = 1'b0;
    @(posedge clk);
    @(negedge clk); chk("irq_o_pre_reset", 32'(irq_o), 32'd1);
    @(posedge clk); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h4000_1000; s_pwrite = 1'b0;
    @(posedge clk); #1 s_penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("psel_inflight", 32'(m_psel), 32'b0010);
    @(posedge clk); #1;
    resetn = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_psel", 32'(m_psel), 32'd0);
    chk("post_rst_irq_o", 32'(irq_o), 32'd0);
    chk("post_rst_pready", 32'(s_pready), 32'd0);
    run(mk(0, 32'h4000_F004, 0, -1, 0, 0, 4'b0000, 32'h0, 0, 1));
    run(mk(0, 32'h4000_F00C, 0, -1, 0, 0, 4'b0000, 32'h0, 0, 1));
    run(mk(0, 32'h4000_F000, 0, -1, 0, 0, 4'b0000, 32'h0, 0, 1));
    run(mk(0, 32'h4000_1000, 0, 1, -1, 0, 4'b0010, 32'h0, 1, 9));
    idle();
    run(mk(0, 32'h4000_2000, 0, 2, 0, 0, 4'b0100, 32'hA5A5_0002, 0, 1));
    idle();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
